// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic OV7725-style DVP transmitter emitting RGB565 test frames.
// Optional DVP_TX_FRAME_WM_EN stamps a 16-bit frame number into pixel (0,0) of every frame.
module dvp_pattern_tx #(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int L    = 2 * H_ACT + H_BLANK;
    localparam int CW   = $clog2(L);
    localparam int LM01 = VS_LINES > VBP_LINES ? VS_LINES : VBP_LINES;
    localparam int LM23 = V_ACT > VFP_LINES ? V_ACT : VFP_LINES;
    localparam int LMAX = LM01 > LM23 ? LM01 : LM23;
    localparam int LW   = $clog2(LMAX + 1);
    localparam int BPIX = H_ACT / 8;
    localparam int BW   = $clog2(BPIX + 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} st_t;

    localparam st_t LAST = VFP_LINES > 0 ? VFRONT : V_ACT > 0 ? ACTIVE : VBP_LINES > 0 ? VBACK : VSYNC;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic logic [LW-1:0] last_line(st_t s);
        return s == VSYNC  ? LW'(VS_LINES - 1)  :
               s == VBACK  ? LW'(VBP_LINES - 1) :
               s == ACTIVE ? LW'(V_ACT - 1)     : LW'(VFP_LINES - 1);
    endfunction

    st_t          st_q, st_d, n_vs, n_vb, n_ac, n_vf;
    logic [LW-1:0] line_q, line_d;
    logic [CW-1:0] col_q, col_d;
    logic [15:0]  pcnt_q, pcnt_d, solid_q, solid_d, pix;
    logic [2:0]   bar_q, bar_d;
    logic [BW-1:0] bpix_q, bpix_d;
    logic [1:0]   psel_q, psel_d;
    logic [7:0]   px, data_q, data_d;
    logic         vsync_q, href_q, href_d, done_q, done_d, busy_q;
    logic         start, pix_done;
`ifdef DVP_TX_FRAME_WM_EN
    logic [15:0]  fnum_q;
`endif

    always_comb begin
        n_vf = enable ? VSYNC : IDLE;
        n_ac = VFP_LINES > 0 ? VFRONT : n_vf;
        n_vb = V_ACT > 0 ? ACTIVE : n_ac;
        n_vs = VBP_LINES > 0 ? VBACK : n_vb;
        st_d = st_q;
        line_d = line_q;
        col_d = col_q;
        if (st_q == IDLE) begin
            st_d = enable ? VSYNC : IDLE;
        end else if (col_q != CW'(L - 1)) begin
            col_d = col_q + 1'b1;
        end else begin
            col_d = '0;
            line_d = line_q == last_line(st_q) ? '0 : line_q + 1'b1;
            if (line_q == last_line(st_q))
                st_d = st_q == VSYNC ? n_vs : st_q == VBACK ? n_vb : st_q == ACTIVE ? n_ac : n_vf;
        end
        // Counters wrap to zero at the end of every line/frame, so entry is the only all-zero VSYNC point.
        start = st_d == VSYNC && line_d == '0 && col_d == '0;
        href_d = st_d == ACTIVE && col_d < CW'(2 * H_ACT);
        pix_done = href_d && col_d[0];
        px = 8'(col_d >> 1);
        pix = psel_q == 2'd0 ? BARS[bar_q] :
              psel_q == 2'd1 ? {px[7:3], px[7:2], px[7:3]} :
              psel_q == 2'd2 ? pcnt_q : solid_q;
`ifdef DVP_TX_FRAME_WM_EN
        if (st_d == ACTIVE && line_d == '0 && (col_d >> 1) == '0) pix = fnum_q;
`endif
        data_d = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        pcnt_d = start ? '0 : pix_done ? pcnt_q + 1'b1 : pcnt_q;
        bpix_d = start ? '0 : pix_done ? (bpix_q == BW'(BPIX - 1) ? '0 : bpix_q + 1'b1) : bpix_q;
        bar_d = start ? '0 : pix_done && bpix_q == BW'(BPIX - 1) ? bar_q + 1'b1 : bar_q;
        psel_d = start ? pattern_sel : psel_q;
        solid_d = start ? solid_rgb : solid_q;
        done_d = st_d == LAST && line_d == last_line(LAST) && col_d == CW'(L - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            line_q  <= '0;
            col_q   <= '0;
            pcnt_q  <= '0;
            bpix_q  <= '0;
            bar_q   <= '0;
            psel_q  <= '0;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DVP_TX_FRAME_WM_EN
            fnum_q  <= '0;
`endif
        end else begin
            st_q    <= st_d;
            line_q  <= line_d;
            col_q   <= col_d;
            pcnt_q  <= pcnt_d;
            bpix_q  <= bpix_d;
            bar_q   <= bar_d;
            psel_q  <= psel_d;
            solid_q <= solid_d;
            vsync_q <= st_d == VSYNC;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= st_d != IDLE;
`ifdef DVP_TX_FRAME_WM_EN
            if (done_q) fnum_q <= fnum_q + 1'b1;
`endif
        end
    end

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
endmodule
